// File: rtl/serial_word_rx_pkg.sv
// Shared definitions for the serial word receiver and its sub-module.
package serial_word_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width of a counter able to hold 0..n-1; at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_word_rx_shift_in.sv
// LSB-first shift register with bit counter; presents the word including the bit
// being sampled so the completing edge can load it directly.
module serial_shift_in
  import serial_word_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             load,
  input  logic             shift,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  always_comb begin
    word      = sreg;
    word[cnt] = bit_in;
  end

  assign done = shift && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      // A load always discards whatever partial word was being collected.
      sreg <= {{(WIDTH-1){1'b0}}, bit_in};
      cnt  <= CW'(1);
    end else if (shift) begin
      sreg <= word;
      cnt  <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: assembles LSB-first words, optionally re-negates
// them and offers them on a valid/ready handshake with overrun/frame reporting.
//
// state    | meaning
// ST_IDLE  | waiting for start; bit_in ignored
// ST_SHIFT | collecting bits 1..WIDTH-1 of a word
module serial_word_rx
  import serial_word_rx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit UNDO_COMP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             start,
  input  logic             word_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overrun,
  output logic             frame_err
);

  state_t           state, state_nx;
  logic             load, shift, restart, done;
  logic [WIDTH-1:0] assembled, result;
  logic             drop;

  serial_shift_in #(.WIDTH(WIDTH)) u_shift_in (
    .clk    (clk),
    .reset  (reset),
    .bit_in (bit_in),
    .load   (load),
    .shift  (shift),
    .word   (assembled),
    .done   (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: begin
        if (start)     state_nx = ST_SHIFT;
        else if (done) state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    shift   = 1'b0;
    restart = 1'b0;
    case (state)
      ST_IDLE:  load = start;
      ST_SHIFT: begin
        load    = start;
        restart = start;
        shift   = !start;
      end
      default: ;
    endcase
  end

  // Two's complement wraps, so the most-negative value maps to itself.
  assign result = UNDO_COMP ? (~assembled + WIDTH'(1)) : assembled;
  assign drop   = done && word_valid && !word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= restart;
      if (done && !drop) begin
        word_out   <= result;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Receive end of the serial two's-complement datapath.
- Collects an LSB-first serial bit stream, such as the output of the serial complementer, into a WIDTH-bit parallel word.
- Optionally re-negates the word to recover the original operand, then presents it on a valid/ready output handshake.
- Sits directly after the serial complementer and feeds parallel consumers such as registers or a display driver.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- UNDO_COMP, 1: 1 = word_out is the two's complement of the assembled bits (mod 2^WIDTH); 0 = word_out is the raw assembled bits.

Ports:
- clk  in  1  single clock; rising-edge sampling.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- bit_in  in  1  serial data, LSB first, sampled every rising edge while a word is in progress.
- start  in  1  one-cycle marker sampled together with bit 0 of a word.
- word_ready  in  1  consumer accepts word_out on a rising edge where word_valid=1.
- err_clr  in  1  clears the sticky overrun flag.
- word_out  out  WIDTH  received word; stable while word_valid=1.
- word_valid  out  1  word_out holds an unaccepted word.
- overrun  out  1  sticky: a completed word was dropped.
- frame_err  out  1  one-cycle pulse: a word in progress was aborted by a new start.

Behaviour:
- Reset values: word_out=0, word_valid=0, overrun=0, frame_err=0; state=IDLE, bit counter=0, shift register=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: collecting bits 1..WIDTH-1.
- IDLE:
  - On an edge with start=1: capture bit_in as bit 0, set counter=1, go to SHIFT.
  - start=0: bit_in is ignored.
- SHIFT, each edge:
  - Capture bit_in at bit position counter, then increment counter.
  - When the bit at position WIDTH-1 is captured, the word is complete; return to IDLE on that same edge.
- Latency: word_valid rises in the cycle immediately after the edge that sampled the last bit.
- A new start may coincide with the first IDLE cycle after completion, giving back-to-back words with no gap.
- start=1 while in SHIFT, before completion:
  - Discard the partial word.
  - Treat this edge's bit_in as bit 0 of a new word; counter=1, stay in SHIFT.
  - Pulse frame_err high for exactly the following cycle.
- Output word computation:
  - UNDO_COMP=1: word_out = (~assembled + 1) mod 2^WIDTH. This gives 0 -> 0 and 100..0 -> 100..0 (the most-negative value maps to itself).
  - UNDO_COMP=0: word_out = assembled.
- Handshake:
  - An edge with word_valid=1 and word_ready=1 is a transfer; word_valid drops next cycle.
  - Exception: if a word completes on the same edge as a transfer, the new word loads and word_valid stays 1.
- Overrun: a word completing on an edge with word_valid=1 and word_ready=0 is discarded. word_out is unchanged and overrun is set.
- overrun stays set until an edge with err_clr=1. If err_clr and a new overrun occur on the same edge, set wins.
- Reset asserted mid-word: the partial word is lost and all outputs return to reset values asynchronously. After deassertion, bits are ignored until the next start.
- word_ready and err_clr are don't-care in IDLE with no pending word.

Decomposition:
- Shared package/include holds:
  - State encodings: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default WIDTH constant, shared with the complementer bench.
  - Counter width function clog2(WIDTH).
- One natural sub-module, serial_shift_in: LSB-first shift register plus bit counter. Outputs are the assembled word and a done pulse.
- The FSM, negation, handshake and error logic live in the top.

Test Plan (WIDTH=8, UNDO_COMP=1):
- Basic decode: start with bit 0, then bits 1,1,0,1,1,1,1,1 (0xFB, the complement of 5) on consecutive edges, word_ready=1 → word_valid high one cycle after the 8th bit, word_out=0x05, then word_valid=0.
- Back-to-back: 0xFB followed immediately by 0x80 (start on the next edge), word_ready held 0 until the second word completes → first word_out=0x05 is held, second word dropped, overrun=1. err_clr pulse → overrun=0.
- Simultaneous transfer and completion: word_ready=1 on the completing edge of a second word 0xFF → word_valid stays 1, word_out changes 0x05 → 0x01.
- Restart: start at bit index 4 of a word in progress → frame_err pulses one cycle. The new word 0xFE (complement of 2) completes 8 edges after the restart with word_out=0x02.
- Boundaries: 0x00 → 0x00; 0x80 → 0x80. With UNDO_COMP=0, 0xFB → 0xFB.
- Mid-word reset: assert reset after 3 bits → outputs 0 immediately, no word_valid. A complete 0xFB after release yields 0x05.
